mask_txn_sequencer: RTL and testbench

Upstream command stage for the AXI4-Lite mask master. Replaces hand-driven stimulus with an autonomous write-then-readback sweep over NUM_REGS consecutive registers. It drives the master's M_MASK_* user-side request signals and sequences START pulses, waiting on each transaction's completion. It checks readback data and error flags and reports a pass/fail summary to the host-side control logic.

---
 rtl/mask_txn_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_mask_txn_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_txn_sequencer.sv
// mask_txn_sequencer: autonomous write-then-readback sweep over NUM_REGS registers via the mask master.
// Build option: define MASK_SEQ_ADDR_PATTERN_EN to XOR each register's data with its address.
module mask_txn_sequencer #(
  parameter int unsigned NUM_REGS    = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned START_HOLD  = 10,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        go,
  input  logic [31:0] wr_data,
  input  logic [31:0] out_addr,
  input  logic [4:0]  mask_n,
  input  logic        txn_done,
  input  logic [31:0] rd_data,
  input  logic        wr_resp_err,
  input  logic        rd_resp_err,
  output logic        M_MASK_READ_WRITE_TRANSACTION,
  output logic        M_MASK_START_TRANSACTION,
  output logic        M_MASK_VALID,
  output logic [31:0] M_MASK_ADDR,
  output logic [31:0] M_MASK_DATA,
  output logic [31:0] M_MASK_OUTPUT_ADDR,
  output logic [4:0]  M_MASK_N,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [31:0] fail_addr
);

  // state | meaning
  // IDLE  | waiting for go
  // SETUP | address/data/direction presented, VALID high
  // START | START strobe held for START_HOLD cycles
  // WAIT  | waiting for txn_done, bounded by TIMEOUT
  // ADV   | step to next register or to the read phase
  // FIN   | done pulse, pass/fail published
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_WAIT, S_ADV, S_FIN
  } state_t;

  localparam logic [7:0] HOLD_LD  = 8'(START_HOLD - 1);
  localparam logic [7:0] TO_LD    = 8'(TIMEOUT - 1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

`ifdef MASK_SEQ_ADDR_PATTERN_EN
  localparam logic [31:0] PAT_ADDR_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] PAT_ADDR_MASK = 32'h0000_0000;
`endif

  function automatic logic [31:0] f_addr(input logic [3:0] idx);
    return BASE_ADDR + (32'(idx) * ADDR_STRIDE);
  endfunction

  function automatic logic [31:0] f_reg_data(input logic [31:0] pat, input logic [31:0] addr);
    return pat ^ (addr & PAT_ADDR_MASK);
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_timer;
  logic [3:0]  r_idx;
  logic        r_rw;
  logic [31:0] r_pattern;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_out_addr;
  logic [4:0]  r_mask_n;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [4:0]  r_err_count;
  logic [31:0] r_fail_addr;

  logic        w_txn_end;
  logic        w_txn_err;
  logic        w_rd_bad;
  logic [3:0]  w_idx_inc;
  logic [31:0] w_addr_inc;

  assign w_rd_bad   = rd_resp_err || (rd_data != r_data);
  assign w_idx_inc  = r_idx + 4'd1;
  assign w_addr_inc = f_addr(w_idx_inc);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_txn_end    = 1'b0;
    w_txn_err    = 1'b0;
    case (r_state)
      S_IDLE:  if (go) w_next_state = S_SETUP;
      S_SETUP: w_next_state = S_START;
      S_START: if (r_timer == 8'd0) w_next_state = S_WAIT;
      S_WAIT: begin
        // a completion in the final timeout cycle wins over the timeout
        if (txn_done) begin
          w_txn_end = 1'b1;
          w_txn_err = r_rw ? w_rd_bad : wr_resp_err;
        end else if (r_timer == 8'd0) begin
          w_txn_end = 1'b1;
          w_txn_err = 1'b1;
        end
        if (w_txn_end) w_next_state = S_ADV;
      end
      S_ADV: begin
        if (r_idx == LAST_IDX && r_rw) w_next_state = S_FIN;
        else                           w_next_state = S_SETUP;
      end
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_timer     <= '0;
      r_idx       <= '0;
      r_rw        <= 1'b0;
      r_pattern   <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_out_addr  <= '0;
      r_mask_n    <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_fail_addr <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_pattern   <= wr_data;
            r_out_addr  <= out_addr;
            r_mask_n    <= mask_n;
            r_err_count <= '0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_idx       <= '0;
            r_rw        <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_data      <= f_reg_data(wr_data, BASE_ADDR);
            r_busy      <= 1'b1;
            r_valid     <= 1'b1;
          end
        end
        S_SETUP: r_timer <= HOLD_LD;
        S_START: begin
          if (r_timer == 8'd0) r_timer <= TO_LD;
          else                 r_timer <= r_timer - 8'd1;
        end
        S_WAIT: begin
          if (!w_txn_end) r_timer <= r_timer - 8'd1;
          if (w_txn_err) begin
            if (r_err_count != 5'd31) r_err_count <= r_err_count + 5'd1;
            if (r_err_count == 5'd0)  r_fail_addr <= r_addr;
          end
        end
        S_ADV: begin
          if (r_idx != LAST_IDX) begin
            r_idx  <= w_idx_inc;
            r_addr <= w_addr_inc;
            r_data <= f_reg_data(r_pattern, w_addr_inc);
          end else if (!r_rw) begin
            r_rw   <= 1'b1;
            r_idx  <= '0;
            r_addr <= BASE_ADDR;
            r_data <= f_reg_data(r_pattern, BASE_ADDR);
          end else begin
            r_done  <= 1'b1;
            r_pass  <= (r_err_count == 5'd0);
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign M_MASK_START_TRANSACTION      = (r_state == S_START);
  assign M_MASK_READ_WRITE_TRANSACTION = r_rw;
  assign M_MASK_VALID                  = r_valid;
  assign M_MASK_ADDR                   = r_addr;
  assign M_MASK_DATA                   = r_data;
  assign M_MASK_OUTPUT_ADDR            = r_out_addr;
  assign M_MASK_N                      = r_mask_n;
  assign busy                          = r_busy;
  assign done                          = r_done;
  assign pass                          = r_pass;
  assign err_count                     = r_err_count;
  assign fail_addr                     = r_fail_addr;

endmodule

// File: tb/tb_mask_txn_sequencer.sv
// tb_mask_txn_sequencer: drives sweeps against an echoing responder and checks them against a reference model.
`timescale 1ns/1ps
module tb_mask_txn_sequencer;
  localparam int N = 4;
  localparam int SH = 10;
  localparam int TO = 255;
  localparam logic [31:0] BASE = 32'h0;
  localparam int STRIDE = 4;

  logic aclk = 1'b0, areset = 1'b1, go = 1'b0;
  logic [31:0] wr_data = '0, out_addr = '0, rd_data = '0;
  logic [4:0] mask_n = '0;
  logic txn_done = 1'b0, wr_resp_err = 1'b0, rd_resp_err = 1'b0;
  logic rw_o, start_o, valid_o, busy, done, pass;
  logic [31:0] addr_o, data_o, oaddr_o, fail_addr;
  logic [4:0] maskn_o, err_count;

  always #5 aclk = ~aclk;

  mask_txn_sequencer #(.NUM_REGS(N), .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE),
                       .START_HOLD(SH), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset), .go(go), .wr_data(wr_data), .out_addr(out_addr),
    .mask_n(mask_n), .txn_done(txn_done), .rd_data(rd_data), .wr_resp_err(wr_resp_err),
    .rd_resp_err(rd_resp_err), .M_MASK_READ_WRITE_TRANSACTION(rw_o),
    .M_MASK_START_TRANSACTION(start_o), .M_MASK_VALID(valid_o), .M_MASK_ADDR(addr_o),
    .M_MASK_DATA(data_o), .M_MASK_OUTPUT_ADDR(oaddr_o), .M_MASK_N(maskn_o), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .fail_addr(fail_addr));

  typedef struct packed { logic rw; logic [31:0] addr; logic [31:0] data; } txn_t;

  int ncmp = 0, nerr = 0;
  int resp_delay = 0;
  bit resp_silent = 0, inj_rd_bad = 0, inj_wr_err = 0, inj_rd_err = 0;
  logic [31:0] bad_rd_addr = '0, wr_err_addr = '0, rd_err_addr = '0;
  logic [31:0] drv_oaddr = '0;
  logic [4:0] drv_maskn = '0;
  logic [31:0] mem [logic [31:0]];
  txn_t log_q[$], exp_q[$];
  int hold_q[$];
  int hold_cnt = 0, wait_cnt = 0, done_cnt = 0;
  bit prev_start = 0, pending = 0;
  txn_t cur;

  // Slave-side responder and bus monitor: logs each transaction when START falls.
  always @(negedge aclk) begin
    if (areset) begin
      prev_start = 0; hold_cnt = 0; pending = 0;
      txn_done = 0; wr_resp_err = 0; rd_resp_err = 0;
    end else begin
      if (txn_done) begin txn_done = 0; wr_resp_err = 0; rd_resp_err = 0; end
      if (start_o) hold_cnt++;
      if (prev_start && !start_o) begin
        cur = '{rw: rw_o, addr: addr_o, data: data_o};
        log_q.push_back(cur); hold_q.push_back(hold_cnt); hold_cnt = 0;
        pending = !resp_silent; wait_cnt = resp_delay;
      end
      if (pending) begin
        if (wait_cnt == 0) begin
          pending = 0; txn_done = 1;
          if (!cur.rw) begin
            mem[cur.addr] = cur.data;
            wr_resp_err = inj_wr_err && (cur.addr == wr_err_addr);
          end else begin
            if (inj_rd_bad && cur.addr == bad_rd_addr) rd_data = 32'h0;
            else if (mem.exists(cur.addr))            rd_data = mem[cur.addr];
            else                                      rd_data = 32'hDEAD_BEEF;
            rd_resp_err = inj_rd_err && (cur.addr == rd_err_addr);
          end
        end else wait_cnt--;
      end
      prev_start = start_o;
      if (done) done_cnt++;
    end
  end

  function automatic logic [31:0] exp_data(input logic [31:0] pat, input logic [31:0] a);
`ifdef MASK_SEQ_ADDR_PATTERN_EN
    return pat ^ a;
`else
    return pat | (a & 32'h0);
`endif
  endfunction

  // Reference: list every write then every read, and score each against the injected faults.
  task automatic model(input logic [31:0] pat, output bit e_pass, output logic [4:0] e_cnt,
                       output logic [31:0] e_fa);
    int errs;
    errs = 0; e_fa = '0; exp_q.delete();
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < N; i++) begin
        logic [31:0] a, d, rd;
        bit bad;
        a = BASE + 32'(i * STRIDE);
        d = exp_data(pat, a);
        exp_q.push_back('{rw: (ph == 1), addr: a, data: d});
        if (resp_silent) bad = 1;
        else if (ph == 0) bad = inj_wr_err && (a == wr_err_addr);
        else begin
          rd = (inj_rd_bad && a == bad_rd_addr) ? 32'h0 : d;
          bad = (inj_rd_err && a == rd_err_addr) || (rd != d);
        end
        if (bad) begin
          if (errs == 0) e_fa = a;
          errs++;
        end
      end
    end
    e_cnt = (errs > 31) ? 5'd31 : 5'(errs);
    e_pass = (errs == 0);
  endtask

  task automatic clear_faults();
    resp_silent = 0; inj_rd_bad = 0; inj_wr_err = 0; inj_rd_err = 0; resp_delay = 0;
  endtask

  task automatic do_sweep(input logic [31:0] pat, input int budget, input int go_again_at,
                          output int cyc, output bit timed_out);
    mem.delete(); log_q.delete(); hold_q.delete(); done_cnt = 0;
    @(negedge aclk);
    drv_oaddr = $urandom; drv_maskn = 5'($urandom_range(0, 31));
    wr_data = pat; out_addr = drv_oaddr; mask_n = drv_maskn; go = 1; cyc = 1;
    @(negedge aclk); go = 0; cyc = 2;
    while (!done && cyc < budget) begin
      @(negedge aclk); cyc++;
      go = (cyc == go_again_at);
    end
    go = 0;
    timed_out = !done;
    repeat (3) @(negedge aclk);
  endtask

  task automatic test_reset();
    areset = 1;
    repeat (3) @(negedge aclk);
    ncmp++; if ({start_o, valid_o, busy, done, pass, rw_o} !== 6'b0) begin nerr++;
      $display("FAIL reset_ctrl: got %b want 000000", {start_o, valid_o, busy, done, pass, rw_o}); end
    ncmp++; if ({addr_o, data_o, oaddr_o, fail_addr} !== 128'h0) begin nerr++;
      $display("FAIL reset_data: got %h want 0", {addr_o, data_o, oaddr_o, fail_addr}); end
    ncmp++; if ({maskn_o, err_count} !== 10'h0) begin nerr++;
      $display("FAIL reset_cnt: got %h want 0", {maskn_o, err_count}); end
    areset = 0;
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_basic_echo();
    int cyc; bit to; bit ep; logic [4:0] ec; logic [31:0] fa;
    clear_faults(); resp_delay = 3;
    model(32'hFFFF_FFFF, ep, ec, fa);
    do_sweep(32'hFFFF_FFFF, 1000, 0, cyc, to);
    ncmp++; if (to) begin nerr++; $display("FAIL basic_done: got no done want done"); end
    ncmp++; if (pass !== ep || err_count !== ec || fail_addr !== fa) begin nerr++;
      $display("FAIL basic_result: got %b/%0d/%h want %b/%0d/%h", pass, err_count, fail_addr, ep, ec, fa); end
    ncmp++; if (log_q.size() != exp_q.size()) begin nerr++;
      $display("FAIL basic_txn_count: got %0d want %0d", log_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      ncmp++; if (log_q[i] !== exp_q[i]) begin nerr++;
        $display("FAIL basic_txn%0d: got %h want %h", i, log_q[i], exp_q[i]); end
    end
    foreach (hold_q[i]) begin
      ncmp++; if (hold_q[i] != SH) begin nerr++;
        $display("FAIL start_hold%0d: got %0d want %0d", i, hold_q[i], SH); end
    end
    ncmp++; if (done_cnt != 1) begin nerr++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    ncmp++; if (oaddr_o !== drv_oaddr || maskn_o !== drv_maskn) begin nerr++;
      $display("FAIL passthru: got %h/%h want %h/%h", oaddr_o, maskn_o, drv_oaddr, drv_maskn); end
    ncmp++; if (busy !== 1'b0 || valid_o !== 1'b0) begin nerr++;
      $display("FAIL idle_after: got busy=%b valid=%b want 0/0", busy, valid_o); end
  endtask

  task automatic test_min_latency_go_ignored();
    int cyc; bit to; bit ep; logic [4:0] ec; logic [31:0] fa;
    clear_faults(); resp_delay = 0;
    model(32'h1234_5678, ep, ec, fa);
    do_sweep(32'h1234_5678, 1000, 40, cyc, to);
    ncmp++; if (cyc != 2 * N * (SH + 3) + 2) begin nerr++;
      $display("FAIL min_latency: got %0d want %0d", cyc, 2 * N * (SH + 3) + 2); end
    ncmp++; if (log_q.size() != 2 * N || done_cnt != 1) begin nerr++;
      $display("FAIL go_ignored: got %0d txns %0d dones want %0d/1", log_q.size(), done_cnt, 2 * N); end
    ncmp++; if (pass !== ep) begin nerr++; $display("FAIL min_pass: got %b want %b", pass, ep); end
  endtask

  task automatic test_read_mismatch();
    int cyc; bit to; bit ep; logic [4:0] ec; logic [31:0] fa;
    clear_faults(); resp_delay = 3; inj_rd_bad = 1; bad_rd_addr = BASE + 32'(2 * STRIDE);
    model(32'hFFFF_FFFF, ep, ec, fa);
    do_sweep(32'hFFFF_FFFF, 1000, 0, cyc, to);
    ncmp++; if (to || pass !== ep || err_count !== ec || fail_addr !== fa) begin nerr++;
      $display("FAIL rd_mismatch: got %b/%0d/%h want %b/%0d/%h", pass, err_count, fail_addr, ep, ec, fa); end
  endtask

  task automatic test_resp_errors();
    int cyc; bit to; bit ep; logic [4:0] ec; logic [31:0] fa;
    clear_faults(); resp_delay = 2;
    inj_wr_err = 1; wr_err_addr = BASE + 32'(STRIDE);
    inj_rd_err = 1; rd_err_addr = BASE + 32'(3 * STRIDE);
    model(32'hCAFE_F00D, ep, ec, fa);
    do_sweep(32'hCAFE_F00D, 1000, 0, cyc, to);
    ncmp++; if (to || pass !== ep || err_count !== ec || fail_addr !== fa) begin nerr++;
      $display("FAIL resp_err: got %b/%0d/%h want %b/%0d/%h", pass, err_count, fail_addr, ep, ec, fa); end
  endtask

  task automatic test_timeout();
    int cyc; bit to; bit ep; logic [4:0] ec; logic [31:0] fa;
    clear_faults(); resp_silent = 1;
    model(32'h0F0F_0F0F, ep, ec, fa);
    do_sweep(32'h0F0F_0F0F, 4000, 0, cyc, to);
    ncmp++; if (to || done_cnt != 1) begin nerr++;
      $display("FAIL timeout_done: got timed_out=%b dones=%0d want 0/1", to, done_cnt); end
    ncmp++; if (pass !== ep || err_count !== ec || fail_addr !== fa) begin nerr++;
      $display("FAIL timeout_result: got %b/%0d/%h want %b/%0d/%h", pass, err_count, fail_addr, ep, ec, fa); end
  endtask

  task automatic test_timeout_boundary();
    int cyc; bit to; bit ep; logic [4:0] ec; logic [31:0] fa;
    clear_faults(); resp_delay = TO - 1;
    model(32'h5555_AAAA, ep, ec, fa);
    do_sweep(32'h5555_AAAA, 4000, 0, cyc, to);
    ncmp++; if (to || pass !== ep || err_count !== ec) begin nerr++;
      $display("FAIL done_at_timeout: got %b/%0d want %b/%0d", pass, err_count, ep, ec); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int cyc; bit to; bit ep; logic [4:0] ec; logic [31:0] fa; logic [31:0] pat;
      clear_faults();
      pat = (it == 0) ? 32'hA5A5_A5A5 : $urandom;
      resp_delay = $urandom_range(0, 6);
      if (it != 0) begin
        inj_rd_bad = 1'($urandom_range(0, 1)); bad_rd_addr = BASE + 32'($urandom_range(0, N - 1) * STRIDE);
        inj_wr_err = 1'($urandom_range(0, 1)); wr_err_addr = BASE + 32'($urandom_range(0, N - 1) * STRIDE);
        inj_rd_err = 1'($urandom_range(0, 1)); rd_err_addr = BASE + 32'($urandom_range(0, N - 1) * STRIDE);
      end
      model(pat, ep, ec, fa);
      do_sweep(pat, 1000, 0, cyc, to);
      ncmp++; if (to || pass !== ep || err_count !== ec || fail_addr !== fa) begin nerr++;
        $display("FAIL rand%0d_result: got %b/%0d/%h want %b/%0d/%h", it, pass, err_count, fail_addr, ep, ec, fa); end
      ncmp++; if (log_q.size() != exp_q.size()) begin nerr++;
        $display("FAIL rand%0d_count: got %0d want %0d", it, log_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
        ncmp++; if (log_q[i] !== exp_q[i]) begin nerr++;
          $display("FAIL rand%0d_txn%0d: got %h want %h", it, i, log_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, cyc; bit to; bit ep; logic [4:0] ec; logic [31:0] fa;
    clear_faults(); resp_delay = 1;
    mem.delete(); log_q.delete(); hold_q.delete(); done_cnt = 0;
    @(negedge aclk); wr_data = 32'h3C3C_3C3C; go = 1;
    @(negedge aclk); go = 0;
    n = 0;
    while (!(start_o && log_q.size() == 1) && n < 200) begin @(negedge aclk); n++; end
    ncmp++; if (n >= 200) begin nerr++; $display("FAIL reach_start: got no second START want START"); end
    #2 areset = 1;
    #1;
    ncmp++; if ({start_o, busy, valid_o, done} !== 4'b0) begin nerr++;
      $display("FAIL async_reset_ctrl: got %b want 0000", {start_o, busy, valid_o, done}); end
    ncmp++; if ({addr_o, data_o, 27'h0, err_count} !== 96'h0) begin nerr++;
      $display("FAIL async_reset_data: got %h/%h/%0d want 0", addr_o, data_o, err_count); end
    repeat (3) @(negedge aclk);
    areset = 0;
    repeat (3) @(negedge aclk);
    ncmp++; if (done_cnt != 0) begin nerr++; $display("FAIL partial_done: got %0d want 0", done_cnt); end
    model(32'h3C3C_3C3C, ep, ec, fa);
    do_sweep(32'h3C3C_3C3C, 1000, 0, cyc, to);
    ncmp++; if (log_q.size() == 0 || log_q[0] !== exp_q[0]) begin nerr++;
      $display("FAIL restart_first: got %0d txns want first %h", log_q.size(), exp_q[0]); end
    ncmp++; if (to || pass !== ep || err_count !== ec) begin nerr++;
      $display("FAIL restart_result: got %b/%0d want %b/%0d", pass, err_count, ep, ec); end
  endtask

  initial begin
    test_reset();
    test_basic_echo();
    test_min_latency_go_ignored();
    test_read_mismatch();
    test_resp_errors();
    test_random();
    test_reset_mid();
    test_timeout();
    test_timeout_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
